alu36_wb_stage: RTL
===================

// Module: alu36_wb_stage
// PURPOSE
//  Writeback stage directly downstream of the 36-bit ALU (alu36). Registers each ALU result with its
//  sign/overflow/zero outputs and a destination tag into a small FIFO, giving the register-file write
//  port a valid/ready interface. Maintains the architectural condition-flag register (Z, N, V) and a
//  sticky overflow flag. Decouples the combinational ALU from writeback stalls.
// PARAMETERS
//  WIDTH     36  datapath width; must match the ALU sum width
//  TAGW      4   destination-register tag width
//  DEPTH     2   FIFO entries; power of two, >= 2
// PORTS
//  clk        in   1      sole clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      ALU result valid this cycle
//  in_ready   out  1      stage can accept; registered, independent of out_ready
//  in_sum     in   WIDTH  ALU sum
//  in_sign    in   1      ALU sign (sum[WIDTH-1])
//  in_ovf     in   1      ALU signed overflow
//  in_zero    in   1      ALU zero
//  in_tag     in   TAGW   destination register
//  out_valid  out  1      head entry valid
//  out_ready  in   1      register file accepts head entry
//  out_data   out  WIDTH  head entry sum
//  out_tag    out  TAGW   head entry tag
//  out_ovf    out  1      head entry overflow bit
//  flag_z     out  1      zero flag of most recently ACCEPTED result
//  flag_n     out  1      sign flag of most recently accepted result
//  flag_v     out  1      overflow flag of most recently accepted result
//  flag_sv    out  1      sticky overflow
//  clr_sv     in   1      synchronous clear of flag_sv
//  count      out  log2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - rst asserted (any time, mid-transfer included): all entries discarded, rd/wr pointers=0, count=0,
//    in_ready=1 on release, out_valid=0, out_data/out_tag/out_ovf=0, flag_z/n/v/sv=0.
//  - push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated on the rising clk edge.
//  - in_ready = (count != DEPTH). When full, in_valid is ignored and no state changes; the producer holds.
//  - Latency: entry pushed at edge N is visible on out_valid/out_data after edge N (1 cycle, FWFT).
//  - out_data/out_tag/out_ovf are stable while out_valid=1 and out_ready=0.
//  - push & pop same edge: count unchanged; legal at any non-empty, non-full occupancy. Empty: pop
//    impossible (out_valid=0); no bypass, so the new entry appears next cycle. Full: push blocked, pop
//    proceeds, in_ready rises the cycle after.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count saturates nowhere (cannot exceed DEPTH).
//  - Flags update on push only: flag_z<=in_zero, flag_n<=in_sign, flag_v<=in_ovf; otherwise hold.
//    Flags are not affected by pop or by stalls.
//  - flag_sv: set on push with in_ovf=1; cleared by clr_sv; set wins when both occur on the same edge.
//  - No data arithmetic is performed; in_sum passes bit-exact, all WIDTH bits.
// TESTING
//  - Reset: rst pulse mid-stream with 2 entries held -> count=0, out_valid=0, in_ready=1, all flags 0.
//  - Single push sum=36'h000000005, tag=3, out_ready=1 -> out_valid next cycle, data 5, tag 3, popped;
//    flag_z=0, flag_n=0.
//  - Fill: push 36'h800000000 (sign=1) then 36'h0 (zero=1), out_ready=0 -> count=2, in_ready=0,
//    flag_z=1, flag_n=0; third push held; release out_ready -> pops in order 800000000, 0.
//  - Simultaneous push+pop at count=1 for 8 cycles with incrementing data -> count stays 1, order kept,
//    pointers wrap correctly.
//  - Sticky: push with ovf=1 then ovf=0 -> flag_v=0, flag_sv=1; clr_sv with concurrent ovf=1 push ->
//    flag_sv stays 1; clr_sv alone -> flag_sv=0.
//  - Backpressure stability: out_ready=0 for 5 cycles -> out_data/out_tag unchanged throughout.

Source files
------------

// File: rtl/alu36_wb_stage.sv
// Writeback stage behind the 36-bit ALU: small FWFT result FIFO with valid/ready on both sides,
// plus the architectural Z/N/V condition flags and a sticky overflow flag.
module alu36_wb_stage #(
  parameter int WIDTH = 36,
  parameter int TAGW  = 4,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_sum,
  input  logic                       in_sign,
  input  logic                       in_ovf,
  input  logic                       in_zero,
  input  logic [TAGW-1:0]            in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [TAGW-1:0]            out_tag,
  output logic                       out_ovf,
  output logic                       flag_z,
  output logic                       flag_n,
  output logic                       flag_v,
  output logic                       flag_sv,
  input  logic                       clr_sv,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             flag_z_q, flag_n_q, flag_v_q;
  logic             flag_sv_q, flag_sv_d;
  logic             push, pop;

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [TAGW-1:0]  tag_mem  [DEPTH];
  logic             ovf_mem  [DEPTH];

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Both handshake outputs are registered so neither depends combinationally on the other side.
    in_ready_d  = (count_d != FULL_CNT);
    out_valid_d = (count_d != '0);
    flag_sv_d   = (push & in_ovf) | (flag_sv_q & ~clr_sv);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_n_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      flag_sv_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      flag_sv_q   <= flag_sv_d;
      if (push) begin
        flag_z_q <= in_zero;
        flag_n_q <= in_sign;
        flag_v_q <= in_ovf;
      end
    end
  end

  // Storage carries no reset; stale contents are hidden by gating the head with out_valid.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_q == PTRW'(gi))) begin
        data_mem[gi] <= in_sum;
        tag_mem[gi]  <= in_tag;
        ovf_mem[gi]  <= in_ovf;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? data_mem[rd_ptr_q] : '0;
  assign out_tag   = out_valid_q ? tag_mem[rd_ptr_q]  : '0;
  assign out_ovf   = out_valid_q ? ovf_mem[rd_ptr_q]  : 1'b0;
  assign flag_z    = flag_z_q;
  assign flag_n    = flag_n_q;
  assign flag_v    = flag_v_q;
  assign flag_sv   = flag_sv_q;
  assign count     = count_q;

endmodule
